// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU datapath.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;

  // Writeback source select encodings
  localparam logic WB_SEL_MEM  = 1'b0;
  localparam logic WB_SEL_CALC = 1'b1;

endpackage : cpu_pkg

// File: rtl/mux_2.sv
// Parameterised 2:1 multiplexer, shared across the datapath.
module mux_2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             select,
  output logic [WIDTH-1:0] out
);

  // Pick data1 when select is high, otherwise data0; the unselected input never reaches out
  always_comb begin
    out = data0;
    if (select) begin
      out = data1;
    end
  end

endmodule : mux_2

// File: rtl/memory_writeback_register.sv
// Memory/Writeback pipeline register with the writeback source-select mux.
module memory_writeback_register
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             wbs_in,
  input  logic [WIDTH-1:0] memData_in,
  input  logic [WIDTH-1:0] calcData_in,
  input  logic             ni_in,
  output logic             wbs_out,
  output logic [WIDTH-1:0] memData_out,
  output logic [WIDTH-1:0] calcData_out,
  output logic             ni_out,
  output logic [WIDTH-1:0] wb_data
);

  // Stage registers: reset/flush load a bubble, flush beats stall, stall holds, else load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_out      <= WB_SEL_MEM;
      memData_out  <= '0;
      calcData_out <= '0;
      ni_out       <= 1'b0;
    end else if (flush) begin
      wbs_out      <= WB_SEL_MEM;
      memData_out  <= '0;
      calcData_out <= '0;
      ni_out       <= 1'b0;
    end else if (!stall) begin
      wbs_out      <= wbs_in;
      memData_out  <= memData_in;
      calcData_out <= calcData_in;
      ni_out       <= ni_in;
    end
  end

  // Writeback data is chosen only from the registered values, never from the inputs
  mux_2 #(
    .WIDTH(WIDTH)
  ) u_wb_mux (
    .data0 (memData_out),
    .data1 (calcData_out),
    .select(wbs_out),
    .out   (wb_data)
  );

endmodule : memory_writeback_register

// File: tb/tb_memory_writeback_register.sv
// Directed self-checking bench for memory_writeback_register.
module tb_memory_writeback_register;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             flush;
  logic             wbs_in;
  logic [WIDTH-1:0] memData_in;
  logic [WIDTH-1:0] calcData_in;
  logic             ni_in;
  logic             wbs_out;
  logic [WIDTH-1:0] memData_out;
  logic [WIDTH-1:0] calcData_out;
  logic             ni_out;
  logic [WIDTH-1:0] wb_data;

  int checkCount = 0;
  int failCount  = 0;

  memory_writeback_register #(
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .wbs_in      (wbs_in),
    .memData_in  (memData_in),
    .calcData_in (calcData_in),
    .ni_in       (ni_in),
    .wbs_out     (wbs_out),
    .memData_out (memData_out),
    .calcData_out(calcData_out),
    .ni_out      (ni_out),
    .wb_data     (wb_data)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setInputs(input logic wbs, input logic [WIDTH-1:0] mem,
                           input logic [WIDTH-1:0] calc, input logic ni);
    wbs_in      = wbs;
    memData_in  = mem;
    calcData_in = calc;
    ni_in       = ni;
  endtask

  // Drive inputs, then sample 1 ns after the next rising edge
  task automatic applyStimulus(input logic wbs, input logic [WIDTH-1:0] mem,
                               input logic [WIDTH-1:0] calc, input logic ni);
    setInputs(wbs, mem, calc, ni);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic wbs, input logic [WIDTH-1:0] mem,
                          input logic [WIDTH-1:0] calc, input logic ni,
                          input logic [WIDTH-1:0] wb);
    checkOutput({tag, "_wbs"},  {15'd0, wbs_out}, {15'd0, wbs});
    checkOutput({tag, "_mem"},  memData_out, mem);
    checkOutput({tag, "_calc"}, calcData_out, calc);
    checkOutput({tag, "_ni"},   {15'd0, ni_out}, {15'd0, ni});
    checkOutput({tag, "_wb"},   wb_data, wb);
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    setInputs(1'b1, 16'h00FF, 16'hFF00, 1'b1);

    // Reset held across several edges with live inputs
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Release between edges; first edge loads
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkAll("load_calc", 1'b1, 16'h00FF, 16'hFF00, 1'b1, 16'hFF00);

    applyStimulus(1'b0, 16'h5555, 16'hAAAA, 1'b0);
    checkAll("load_mem", 1'b0, 16'h5555, 16'hAAAA, 1'b0, 16'h5555);

    applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    checkAll("load_calc2", 1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h5555);

    // Stall for three edges while inputs change
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h4321, 16'h1234, 1'b0);
      checkAll("stall", 1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h5555);
    end

    // Flush with stall still high loads a bubble
    flush = 1'b1;
    applyStimulus(1'b0, 16'h4321, 16'h1234, 1'b0);
    checkAll("flush_stall", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Release both: first edge loads current inputs
    flush = 1'b0;
    stall = 1'b0;
    applyStimulus(1'b0, 16'h4321, 16'h1234, 1'b1);
    checkAll("after_stall", 1'b0, 16'h4321, 16'h1234, 1'b1, 16'h4321);

    // Flush alone
    flush = 1'b1;
    applyStimulus(1'b1, 16'h9999, 16'h8888, 1'b1);
    checkAll("flush", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    flush = 1'b0;

    // Load BEEF via calc path, then async reset between edges
    applyStimulus(1'b1, 16'h0123, 16'hBEEF, 1'b1);
    checkAll("pre_async", 1'b1, 16'h0123, 16'hBEEF, 1'b1, 16'hBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1;
    rst_n = 1'b1;
    setInputs(1'b0, 16'h7777, 16'hBEEF, 1'b1);
    #1;
    checkAll("post_release_idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    checkAll("post_release_load", 1'b0, 16'h7777, 16'hBEEF, 1'b1, 16'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule : tb_memory_writeback_register
